// File: rtl/ex_vector_sequencer_if.sv
// ID/EX -> execute -> EX/MEM bundle: instruction fields in, result fields out, each with valid/ready.
// slave is the sequencer's view; master is the upstream/downstream driver's view.
interface ex_vector_sequencer_if #(
    parameter int ELEM_W    = 32,
    parameter int NUM_LANES = 8
);
    localparam int VEC_W = ELEM_W * NUM_LANES;

    logic              in_valid;
    logic              in_ready;
    logic              in_vec;
    logic [2:0]        in_aluop;
    logic              in_opb_bcast;
    logic [ELEM_W-1:0] in_rs1;
    logic [ELEM_W-1:0] in_rs2;
    logic [VEC_W-1:0]  in_vrs1;
    logic [VEC_W-1:0]  in_vrs2;
    logic [4:0]        in_rd;
    logic              in_regwrite;
    logic              in_vregwrite;
    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_result;
    logic [VEC_W-1:0]  out_vresult;
    logic [4:0]        out_rd;
    logic              out_regwrite;
    logic              out_vregwrite;
    logic              stall;

    modport slave (
        input  in_valid, in_vec, in_aluop, in_opb_bcast, in_rs1, in_rs2,
               in_vrs1, in_vrs2, in_rd, in_regwrite, in_vregwrite, out_ready,
        output in_ready, out_valid, out_result, out_vresult, out_rd,
               out_regwrite, out_vregwrite, stall
    );

    modport master (
        output in_valid, in_vec, in_aluop, in_opb_bcast, in_rs1, in_rs2,
               in_vrs1, in_vrs2, in_rd, in_regwrite, in_vregwrite, out_ready,
        input  in_ready, out_valid, out_result, out_vresult, out_rd,
               out_regwrite, out_vregwrite, stall
    );
endinterface

// File: rtl/ex_vector_sequencer.sv
// Execute stage: scalar ops in one cycle, vector ops LANES_PER_CYCLE lanes per cycle,
// result held in DONE until EX/MEM takes it; upstream is stalled while busy.
module ex_vector_sequencer #(
    parameter int ELEM_W          = 32,
    parameter int NUM_LANES       = 8,
    parameter int LANES_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_vector_sequencer_if.slave bus
);
    localparam int VEC_W  = ELEM_W * NUM_LANES;
    localparam int LIDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int SH_W   = $clog2(ELEM_W);
    localparam logic [LIDX_W-1:0] LAST_GRP = LIDX_W'(NUM_LANES - LANES_PER_CYCLE);
    localparam logic [LIDX_W-1:0] GRP_STEP = LIDX_W'(LANES_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [LIDX_W-1:0]  lane_idx;
    logic               accept;
    logic               last_grp;

    logic [2:0]         aluop_p0;
    logic               bcast_p0;
    logic [ELEM_W-1:0]  rs2_p0;
    logic [VEC_W-1:0]   vrs1_p0;
    logic [VEC_W-1:0]   vrs2_p0;
    logic [VEC_W-1:0]   vres_nxt;

    function automatic logic [ELEM_W-1:0] alu(input logic [2:0] op,
                                              input logic [ELEM_W-1:0] a,
                                              input logic [ELEM_W-1:0] b);
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        case (op)
            3'b000:  alu = a + b;
            3'b001:  alu = a - b;
            3'b010:  alu = a & b;
            3'b011:  alu = a | b;
            3'b100:  alu = a ^ b;
            3'b101:  alu = a << sh;
            3'b110:  alu = a >> sh;
            default: alu = a * b;
        endcase
    endfunction

    assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
    assign bus.stall     = bus.in_valid & ~bus.in_ready;
    assign bus.out_valid = (state == DONE);
    assign accept        = bus.in_valid & bus.in_ready;
    assign last_grp      = (lane_idx == LAST_GRP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = bus.in_vec ? RUN : DONE;
            RUN:  if (last_grp) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = accept ? (bus.in_vec ? RUN : DONE) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lane_idx <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                lane_idx <= '0;
            else if (state == RUN)
                lane_idx <= lane_idx + GRP_STEP;
        end
    end

    // p0: operands captured at accept, consumed by the RUN lane groups
    always_ff @(posedge clk) begin
        if (accept) begin
            aluop_p0 <= bus.in_aluop;
            bcast_p0 <= bus.in_opb_bcast;
            rs2_p0   <= bus.in_rs2;
            vrs1_p0  <= bus.in_vrs1;
            vrs2_p0  <= bus.in_vrs2;
        end
    end

    // Only the current lane group is overwritten; earlier lanes keep what is already there.
    always_comb begin
        vres_nxt = bus.out_vresult;
        for (int g = 0; g < LANES_PER_CYCLE; g++) begin
            int base;
            base = (int'(lane_idx) + g) * ELEM_W;
            vres_nxt[base +: ELEM_W] = alu(aluop_p0, vrs1_p0[base +: ELEM_W],
                                           bcast_p0 ? rs2_p0 : vrs2_p0[base +: ELEM_W]);
        end
    end

    // Result registers toward EX/MEM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_result    <= '0;
            bus.out_vresult   <= '0;
            bus.out_rd        <= '0;
            bus.out_regwrite  <= 1'b0;
            bus.out_vregwrite <= 1'b0;
        end else begin
            if (accept) begin
                bus.out_rd        <= bus.in_rd;
                bus.out_regwrite  <= bus.in_regwrite;
                bus.out_vregwrite <= bus.in_vregwrite;
                if (!bus.in_vec)
                    bus.out_result <= alu(bus.in_aluop, bus.in_rs1, bus.in_rs2);
            end
            if (state == RUN)
                bus.out_vresult <= vres_nxt;
        end
    end
endmodule

// File: tb/tb_ex_vector_sequencer.sv
// Directed bench for ex_vector_sequencer: scalar/vector results, latency, stall,
// backpressure, back-to-back accept and reset during RUN.
module tb_ex_vector_sequencer;
    localparam int ELEM_W    = 32;
    localparam int NUM_LANES = 8;
    localparam int LPC       = 2;
    localparam int VEC_W     = ELEM_W * NUM_LANES;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_vector_sequencer_if #(.ELEM_W(ELEM_W), .NUM_LANES(NUM_LANES)) bus ();

    ex_vector_sequencer #(.ELEM_W(ELEM_W), .NUM_LANES(NUM_LANES), .LANES_PER_CYCLE(LPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int lat;
    int seen;
    logic [VEC_W-1:0] va, vb, ve;
    logic [31:0] lane_v;

    logic [2:0]  t_op [9];
    logic [31:0] t_a  [9];
    logic [31:0] t_b  [9];
    logic [31:0] t_e  [9];

    task automatic check_val(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic vec, input logic [2:0] op, input logic bcast,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [VEC_W-1:0] v1, input logic [VEC_W-1:0] v2,
                          input logic [4:0] rd);
        bus.in_vec       = vec;
        bus.in_aluop     = op;
        bus.in_opb_bcast = bcast;
        bus.in_rs1       = rs1;
        bus.in_rs2       = rs2;
        bus.in_vrs1      = v1;
        bus.in_vrs2      = v2;
        bus.in_rd        = rd;
        bus.in_regwrite  = ~vec;
        bus.in_vregwrite = vec;
    endtask

    // Present the bundle for one accept, then wait (bounded) for out_valid.
    task automatic run_op(output int latency);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        latency = 1;
        while (bus.out_valid !== 1'b1 && latency < 12) begin
            step();
            latency++;
        end
    endtask

    task automatic retire(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_val(tag, VEC_W'(bus.out_valid), VEC_W'(0));
    endtask

    initial begin
        t_op = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b111};
        t_a  = '{32'hFFFF_FFFF, 32'd3, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd3, 32'h8000_0000, 32'h0001_0000, 32'h1234};
        t_b  = '{32'd1, 32'd5, 32'hFF00, 32'hFF00, 32'hFF00, 32'h24, 32'h23, 32'h0001_0000, 32'h10};
        t_e  = '{32'd0, 32'hFFFF_FFFE, 32'hF000, 32'hFFF0, 32'h0FF0, 32'h30, 32'h1000_0000, 32'd0, 32'h12340};

        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        set_op(1'b0, 3'b000, 1'b0, 32'd0, 32'd0, '0, '0, 5'd0);
        #2;
        check_val("rst_in_ready", VEC_W'(bus.in_ready), VEC_W'(1));
        check_val("rst_stall", VEC_W'(bus.stall), VEC_W'(0));
        check_val("rst_out_valid", VEC_W'(bus.out_valid), VEC_W'(0));
        check_val("rst_out_result", VEC_W'(bus.out_result), VEC_W'(0));
        check_val("rst_out_vresult", bus.out_vresult, '0);
        check_val("rst_out_rd", VEC_W'(bus.out_rd), VEC_W'(0));
        bus.in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();

        // scalar add 5+7, rd echoed, one-cycle latency
        set_op(1'b0, 3'b000, 1'b0, 32'd5, 32'd7, '0, '0, 5'd3);
        run_op(lat);
        check_val("s_add_lat", VEC_W'(lat), VEC_W'(1));
        check_val("s_add_res", VEC_W'(bus.out_result), VEC_W'(12));
        check_val("s_add_rd", VEC_W'(bus.out_rd), VEC_W'(3));
        check_val("s_add_we", VEC_W'({bus.out_regwrite, bus.out_vregwrite}), VEC_W'(2'b10));
        retire("s_add_retire");

        for (int i = 0; i < 9; i++) begin
            set_op(1'b0, t_op[i], 1'b0, t_a[i], t_b[i], '0, '0, 5'(i));
            run_op(lat);
            check_val($sformatf("s_tab%0d_lat", i), VEC_W'(lat), VEC_W'(1));
            check_val($sformatf("s_tab%0d_res", i), VEC_W'(bus.out_result), VEC_W'(t_e[i]));
            retire($sformatf("s_tab%0d_retire", i));
        end
        check_val("s_vres_kept", bus.out_vresult, '0);

        // vector add with stall observed while upstream holds in_valid
        for (int i = 0; i < NUM_LANES; i++) begin
            va[i*32 +: 32] = 32'(i);
            vb[i*32 +: 32] = 32'(10 * i);
        end
        set_op(1'b1, 3'b000, 1'b0, 32'd0, 32'd0, va, vb, 5'd7);
        bus.in_valid = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NUM_LANES; i++)
                ve[i*32 +: 32] = (i < 2 * k) ? 32'(11 * i) : 32'd0;
            check_val($sformatf("v_add_valid_c%0d", k + 1), VEC_W'(bus.out_valid), VEC_W'(0));
            check_val($sformatf("v_add_stall_c%0d", k + 1), VEC_W'(bus.stall), VEC_W'(1));
            check_val($sformatf("v_add_part_c%0d", k + 1), bus.out_vresult, ve);
            step();
        end
        for (int i = 0; i < NUM_LANES; i++) ve[i*32 +: 32] = 32'(11 * i);
        check_val("v_add_valid_c5", VEC_W'(bus.out_valid), VEC_W'(1));
        check_val("v_add_stall_done", VEC_W'(bus.stall), VEC_W'(1));
        check_val("v_add_res", bus.out_vresult, ve);
        check_val("v_add_scalar_kept", VEC_W'(bus.out_result), VEC_W'(32'h12340));
        check_val("v_add_rd_we", VEC_W'({bus.out_rd, bus.out_regwrite, bus.out_vregwrite}), VEC_W'({5'd7, 2'b01}));
        bus.in_valid = 1'b0;
        retire("v_add_retire");

        // vector mul wraps to low 32 bits
        for (int i = 0; i < NUM_LANES; i++) begin
            va[i*32 +: 32] = (i % 2 == 0) ? 32'h0001_0000 : 32'(i + 2);
            vb[i*32 +: 32] = (i % 2 == 0) ? 32'h0001_0000 : 32'd7;
            ve[i*32 +: 32] = (i % 2 == 0) ? 32'd0 : 32'((i + 2) * 7);
        end
        set_op(1'b1, 3'b111, 1'b0, 32'd0, 32'd0, va, vb, 5'd8);
        run_op(lat);
        check_val("v_mul_lat", VEC_W'(lat), VEC_W'(5));
        check_val("v_mul_res", bus.out_vresult, ve);
        retire("v_mul_retire");

        // broadcast sll: vrs2 lanes would give 2, rs2 broadcast gives 0x10
        for (int i = 0; i < NUM_LANES; i++) begin
            va[i*32 +: 32] = 32'd1;
            vb[i*32 +: 32] = 32'd1;
            ve[i*32 +: 32] = 32'h10;
        end
        set_op(1'b1, 3'b101, 1'b1, 32'd0, 32'd4, va, vb, 5'd9);
        run_op(lat);
        check_val("v_sll_bc_lat", VEC_W'(lat), VEC_W'(5));
        check_val("v_sll_bc_res", bus.out_vresult, ve);
        retire("v_sll_bc_retire");

        // vector sub from vrs2 lanes; rs2 is a distractor, lane 7 wraps
        for (int i = 0; i < NUM_LANES; i++) begin
            va[i*32 +: 32] = (i == 7) ? 32'd0 : 32'(100 + i);
            vb[i*32 +: 32] = 32'(3 * i);
        end
        ve = '0;
        for (int i = 0; i < 7; i++) ve[i*32 +: 32] = 32'(100 - 2 * i);
        ve[7*32 +: 32] = 32'hFFFF_FFEB;
        set_op(1'b1, 3'b001, 1'b0, 32'd0, 32'h55, va, vb, 5'd10);
        run_op(lat);
        check_val("v_sub_lat", VEC_W'(lat), VEC_W'(5));
        check_val("v_sub_res", bus.out_vresult, ve);
        retire("v_sub_retire");

        // backpressure in DONE, then handshake + new accept in the same cycle
        set_op(1'b0, 3'b000, 1'b0, 32'd1, 32'd2, '0, '0, 5'd9);
        run_op(lat);
        set_op(1'b0, 3'b100, 1'b0, 32'hA, 32'h3, '0, '0, 5'd10);
        bus.in_valid = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("bp_valid_%0d", k), VEC_W'(bus.out_valid), VEC_W'(1));
            check_val($sformatf("bp_in_ready_%0d", k), VEC_W'(bus.in_ready), VEC_W'(0));
            check_val($sformatf("bp_stall_%0d", k), VEC_W'(bus.stall), VEC_W'(1));
            check_val($sformatf("bp_hold_%0d", k), VEC_W'({bus.out_rd, bus.out_result}), VEC_W'({5'd9, 32'd3}));
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check_val("b2b_in_ready", VEC_W'(bus.in_ready), VEC_W'(1));
        step();
        bus.in_valid = 1'b0;
        check_val("b2b_valid", VEC_W'(bus.out_valid), VEC_W'(1));
        check_val("b2b_res", VEC_W'({bus.out_rd, bus.out_result}), VEC_W'({5'd10, 32'd9}));
        step();
        bus.out_ready = 1'b0;
        check_val("b2b_idle", VEC_W'(bus.out_valid), VEC_W'(0));

        // reset in RUN cycle 2 discards the vector op
        for (int i = 0; i < NUM_LANES; i++) begin
            va[i*32 +: 32] = 32'(i);
            vb[i*32 +: 32] = 32'(10 * i);
        end
        set_op(1'b1, 3'b000, 1'b0, 32'd0, 32'd0, va, vb, 5'd12);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check_val("rr_valid", VEC_W'(bus.out_valid), VEC_W'(0));
        check_val("rr_vresult", bus.out_vresult, '0);
        check_val("rr_result", VEC_W'(bus.out_result), VEC_W'(0));
        check_val("rr_rd_we", VEC_W'({bus.out_rd, bus.out_regwrite, bus.out_vregwrite}), VEC_W'(0));
        check_val("rr_in_ready", VEC_W'(bus.in_ready), VEC_W'(1));
        step();
        rst = 1'b1;
        seen = 0;
        repeat (8) begin
            step();
            if (bus.out_valid === 1'b1) seen++;
        end
        check_val("rr_no_valid", VEC_W'(seen), VEC_W'(0));

        for (int i = 0; i < NUM_LANES; i++) ve[i*32 +: 32] = 32'(11 * i);
        run_op(lat);
        check_val("rr_next_lat", VEC_W'(lat), VEC_W'(5));
        check_val("rr_next_res", bus.out_vresult, ve);
        retire("rr_next_retire");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
